// File: rtl/fe_mulsq_seq.sv
// Sequential pseudo-Mersenne field multiplier / repeated squarer.
// Field: p = 2^(NLIMB*LW) - FOLD_C (default GF(2^255-19), 5 x 51-bit limbs).
// One operation in flight. The schoolbook product goes into a 2*NLIMB-column
// accumulator one b-limb per cycle. It is then folded once and carried in
// passes until no carry leaves the top limb.
// Handshake: a request is accepted on the rising edge where valid & ready.
// ready is high only in IDLE. done pulses for one cycle, and res holds the
// result from that cycle until the next accepted op completes.
module fe_mulsq_seq #(
  parameter int NLIMB  = 5,
  parameter int LW     = 51,
  parameter int FOLD_C = 19,
  parameter int KW     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid,
  output logic                ready,
  input  logic                mode,
  input  logic [KW-1:0]       sq_count,
  input  logic [NLIMB*LW-1:0] op_a,
  input  logic [NLIMB*LW-1:0] op_b,
  output logic [NLIMB*LW-1:0] res,
  output logic                done,
  output logic                busy,
  output logic [2:0]          dbg_state
);

  localparam int W    = NLIMB * LW;
  // Column width covers NLIMB summed limb products, the fold by FOLD_C and the carry headroom.
  localparam int CW   = 2*LW + $clog2(NLIMB) + $clog2(FOLD_C+1) + 2;
  localparam int CNTW = (NLIMB > 1) ? $clog2(NLIMB) : 1;
  localparam logic [CW-1:0]   FOLD_K = CW'(FOLD_C);
  localparam logic [CNTW-1:0] LAST   = CNTW'(NLIMB-1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MUL   = 3'd1,
    S_FOLD  = 3'd2,
    S_CARRY = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            mode_q, mode_d;
  logic [KW-1:0]   iter_q, iter_d;
  logic [CW-1:0]   wrap_q, wrap_d;
  logic [W-1:0]    res_q, res_d;
  logic [CW-1:0]   acc_q [2*NLIMB];
  logic [CW-1:0]   acc_d [2*NLIMB];

  // Datapath temporaries.
  logic [W-1:0]    b_src;
  logic [LW-1:0]   b_limb;
  logic [CW-1:0]   prod [NLIMB];
  logic [CW-1:0]   cur;
  logic [CW-1:0]   carry;
  logic [CW-1:0]   low;
  logic [W-1:0]    carried;

  // State, operand, accumulator and result registers; reset aborts any op in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      iter_q  <= '0;
      wrap_q  <= '0;
      res_q   <= '0;
      for (int i = 0; i < 2*NLIMB; i++) acc_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      iter_q  <= iter_d;
      wrap_q  <= wrap_d;
      res_q   <= res_d;
      for (int i = 0; i < 2*NLIMB; i++) acc_q[i] <= acc_d[i];
    end
  end

  // Next-state logic and the per-cycle accumulator update for each phase.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    iter_d  = iter_q;
    wrap_d  = wrap_q;
    res_d   = res_q;
    for (int i = 0; i < 2*NLIMB; i++) acc_d[i] = acc_q[i];

    // In squaring mode the multiplier operand is a itself.
    b_src  = mode_q ? a_q : b_q;
    b_limb = '0;
    for (int i = 0; i < NLIMB; i++) begin
      if (i == int'(cnt_q)) b_limb = b_src[i*LW +: LW];
    end
    for (int j = 0; j < NLIMB; j++) begin
      prod[j] = CW'(a_q[j*LW +: LW]) * CW'(b_limb);
    end

    cur = '0;
    for (int i = 0; i < NLIMB; i++) begin
      if (i == int'(cnt_q)) cur = acc_q[i];
    end
    // Wrapped carry re-enters at limb 0 at the start of every pass.
    if (cnt_q == '0) cur = cur + FOLD_K * wrap_q;
    carry   = cur >> LW;
    low     = {{(CW-LW){1'b0}}, cur[LW-1:0]};
    carried = '0;

    case (state_q)
      S_IDLE: begin
        if (valid) begin
          a_d    = op_a;
          b_d    = op_b;
          mode_d = mode;
          iter_d = (sq_count == '0) ? KW'(1) : sq_count;
          cnt_d  = '0;
          wrap_d = '0;
          for (int i = 0; i < 2*NLIMB; i++) acc_d[i] = '0;
          state_d = S_MUL;
        end
      end

      S_MUL: begin
        // Row cnt: a * b[cnt] lands in columns cnt .. cnt+NLIMB-1.
        for (int i = 0; i < NLIMB; i++) begin
          if (i == int'(cnt_q)) begin
            for (int j = 0; j < NLIMB; j++) acc_d[i+j] = acc_q[i+j] + prod[j];
          end
        end
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_FOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_FOLD: begin
        // 2^(NLIMB*LW) == FOLD_C, so the upper half folds down with weight FOLD_C.
        for (int j = 0; j < NLIMB; j++) begin
          acc_d[j]       = acc_q[j] + FOLD_K * acc_q[j+NLIMB];
          acc_d[j+NLIMB] = '0;
        end
        wrap_d  = '0;
        cnt_d   = '0;
        state_d = S_CARRY;
      end

      S_CARRY: begin
        for (int i = 0; i < NLIMB; i++) begin
          if (i == int'(cnt_q)) begin
            acc_d[i] = low;
            if (i < NLIMB-1) acc_d[i+1] = acc_q[i+1] + carry;
          end
        end
        if (cnt_q == LAST) begin
          cnt_d  = '0;
          wrap_d = carry;
          if (carry == '0) begin
            for (int j = 0; j < NLIMB; j++) carried[j*LW +: LW] = acc_d[j][LW-1:0];
            if (mode_q && (iter_q > KW'(1))) begin
              // Another squaring: the reduced value becomes the next operand.
              a_d    = carried;
              iter_d = iter_q - 1'b1;
              for (int i = 0; i < 2*NLIMB; i++) acc_d[i] = '0;
              state_d = S_MUL;
            end else begin
              res_d   = carried;
              state_d = S_DONE;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ready     = (state_q == S_IDLE);
  assign done      = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign res       = res_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fe_mulsq_seq.sv
// Bench for fe_mulsq_seq in its default GF(2^255-19) configuration.
// Driver tasks issue requests and push the expected result into a queue.
// A monitor pops an entry at every done pulse and compares it, including a latency bound.
module tb_fe_mulsq_seq;

  localparam int W = 255;
  localparam logic [W-1:0] P    = {W{1'b1}} - W'(18);
  localparam logic [W-1:0] ONES = {W{1'b1}};

  // Clock and reset.
  logic         clk = 1'b0;
  logic         rst;
  logic         valid;
  logic         ready;
  logic         mode;
  logic [7:0]   sq_count;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [W-1:0] res;
  logic         done;
  logic         busy;
  logic [2:0]   dbg_state;

  int cyc      = 0;
  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fe_mulsq_seq #(.NLIMB(5), .LW(51), .FOLD_C(19), .KW(8)) dut (
    .clk(clk), .rst(rst), .valid(valid), .ready(ready), .mode(mode),
    .sq_count(sq_count), .op_a(op_a), .op_b(op_b), .res(res),
    .done(done), .busy(busy), .dbg_state(dbg_state)
  );

  // Scoreboard queues.
  logic [W-1:0] exp_q[$];
  bit           exact_q[$];
  int           acyc_q[$];
  int           mlat_q[$];

  function automatic void check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endfunction

  function automatic logic [W-1:0] mod_p(input logic [W-1:0] x);
    return (x >= P) ? x - P : x;
  endfunction

  function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] pr;
    logic [2*W-1:0] pp;
    pr = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    pp = {{W{1'b0}}, P};
    pr = pr % pp;
    return pr[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [255:0] t;
    t = '0;
    for (int i = 0; i < 8; i++) t = {t[223:0], 32'($urandom)};
    return t[W-1:0];
  endfunction

  task automatic push_exp(input logic [W-1:0] e, input bit exact, input int iters);
    exp_q.push_back(e);
    exact_q.push_back(exact);
    acyc_q.push_back(cyc + 1);
    mlat_q.push_back(iters * 22 + 1);
  endtask

  // Wait (bounded) for ready at a falling edge.
  task automatic wait_ready();
    int g;
    g = 0;
    @(negedge clk);
    while (!ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!ready) check("ready_timeout", W'(ready), W'(1));
  endtask

  // Driver: one request, held valid for exactly one accepting edge.
  task automatic issue(input logic m, input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] e, input bit exact);
    int iters;
    iters = (m && k > 1) ? k : 1;
    wait_ready();
    valid    = 1'b1;
    mode     = m;
    sq_count = 8'(k);
    op_a     = a;
    op_b     = b;
    push_exp(e, exact, iters);
    @(negedge clk);
    valid = 1'b0;
  endtask

  // Monitor: compares every done pulse against the head of the expected queue.
  initial begin
    logic [W-1:0] e;
    bit           x;
    int           ac;
    int           ml;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        n_done++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", W'(done), W'(0));
        end else begin
          e  = exp_q.pop_front();
          x  = exact_q.pop_front();
          ac = acyc_q.pop_front();
          ml = mlat_q.pop_front();
          if (x) check("res_exact", res, e);
          else   check("res_mod_p", mod_p(res), e);
          check("latency_bound", W'((cyc - ac) <= ml), W'(1));
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Stimulus.
  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] e;
    int           k;
    int           g;
    int           done_before;

    rst = 1'b1; valid = 1'b0; mode = 1'b0; sq_count = '0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", W'(ready), W'(1));
    check("rst_done",  W'(done),  W'(0));
    check("rst_busy",  W'(busy),  W'(0));
    check("rst_res",   res,       '0);
    rst = 1'b0;

    // Directed multiplies.
    issue(1'b0, 0, W'(1), W'(1), W'(1), 1'b1);
    issue(1'b0, 0, P - W'(1), P - W'(1), W'(1), 1'b0);
    issue(1'b0, 0, ONES, W'(2), W'(36), 1'b1);
    issue(1'b0, 0, W'(1) << 254, W'(2), W'(19), 1'b1);
    issue(1'b0, 0, P, W'(5), W'(0), 1'b0);
    issue(1'b0, 0, P + W'(5), W'(3), W'(15), 1'b0);

    // Directed repeated squaring; op_b must be ignored.
    issue(1'b1, 3, W'(3), ONES, W'(6561), 1'b1);
    issue(1'b1, 0, W'(3), W'(77), W'(9), 1'b1);
    issue(1'b1, 8, W'(2), W'(0), W'(38), 1'b1);
    issue(1'b1, 2, P - W'(1), W'(5), W'(1), 1'b0);

    // valid held high: busy during the op, a second accept right after done.
    wait_ready();
    valid = 1'b1; mode = 1'b0; sq_count = '0; op_a = W'(12345); op_b = W'(678);
    push_exp(W'(8369910), 1'b1, 1);
    @(negedge clk);
    check("hold_ready_low", W'(ready), W'(0));
    check("hold_busy_high", W'(busy),  W'(1));
    g = 0;
    while (!done && g < 40) begin
      @(negedge clk);
      g++;
    end
    check("hold_done_seen", W'(done), W'(1));
    @(negedge clk);
    check("idle_after_done", W'(ready), W'(1));
    op_a = W'(1000); op_b = W'(1000);
    push_exp(W'(1000000), 1'b1, 1);
    @(negedge clk);
    valid = 1'b0;
    check("b2b_accepted", W'(busy), W'(1));

    // Reset during MUL cycle 2 aborts the op.
    wait_ready();
    valid = 1'b1; mode = 1'b0; op_a = W'(5); op_b = W'(7);
    push_exp(W'(35), 1'b1, 1);
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete(); exact_q.delete(); acyc_q.delete(); mlat_q.delete();
    done_before = n_done;
    @(negedge clk);
    check("abort_res",   res,       '0);
    check("abort_ready", W'(ready), W'(1));
    check("abort_busy",  W'(busy),  W'(0));
    check("abort_done",  W'(done),  W'(0));
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("abort_no_done",   W'(n_done - done_before), W'(0));
    check("abort_res_after", res,                      '0);
    check("abort_ready_after", W'(ready),              W'(1));
    issue(1'b0, 0, W'(1), W'(1), W'(1), 1'b1);

    // Random operands, including values >= p, against the reference model.
    for (int i = 0; i < 6; i++) begin
      a = rand_w();
      b = rand_w();
      if (i % 2 == 0) a = P + W'($urandom_range(0, 18));
      if (i == 3)     b = ONES - W'($urandom_range(0, 18));
      issue(1'b0, 0, a, b, mulmod(a, b), 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      a = rand_w();
      k = $urandom_range(1, 4);
      e = mod_p(a);
      for (int j = 0; j < k; j++) e = mulmod(e, e);
      issue(1'b1, k, a, rand_w(), e, 1'b0);
    end

    // Drain the scoreboard.
    g = 0;
    while (exp_q.size() != 0 && g < 300) begin
      @(negedge clk);
      g++;
    end
    check("drain_empty", W'(exp_q.size()), W'(0));
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
